rand_request_scheduler: RTL and testbench

//  Shares one free-running LFSR random source between NUM_REQ requesters (spawners, enemy AI, bonus drops).

---
 rtl/rand_sched_pkg.sv | 20 ++
 rtl/lfsr_core.sv | 29 ++
 rtl/rand_request_scheduler.sv | 144 ++++++++++++++
 tb/tb_rand_request_scheduler.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rand_sched_pkg.sv
// Shared types, constants and the range-to-mask helper for rand_request_scheduler.
package rand_sched_pkg;

  typedef enum logic [1:0] {IDLE, DRAW, DELIVER} state_t;

  localparam logic [15:0] LFSR_TAPS_16 = 16'hB400;
  localparam logic [15:0] DEFAULT_SEED = 16'hACE1;
  localparam int          MASK_W       = 32;

  // Smear the highest set bit downward: smallest 2^k-1 >= rng (0 -> 0).
  function automatic logic [MASK_W-1:0] range_mask(input logic [MASK_W-1:0] rng);
    logic [MASK_W-1:0] m;
    m = rng;
    for (int s = 1; s < MASK_W; s = s * 2) begin
      m = m | (m >> s);
    end
    return m;
  endfunction

endpackage

// File: rtl/lfsr_core.sv
// Free-running right-shift Galois LFSR with an optional synchronous load (zero data loads SEED).
module lfsr_core
  import rand_sched_pkg::*;
#(
  parameter int               WIDTH = 16,
  parameter logic [WIDTH-1:0] TAPS  = WIDTH'(LFSR_TAPS_16),
  parameter logic [WIDTH-1:0] SEED  = WIDTH'(DEFAULT_SEED)
) (
  input  logic             clk,
  input  logic             resetN,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  output logic [WIDTH-1:0] state
);

  logic [WIDTH-1:0] state_next;

  always_comb begin
    state_next = state >> 1;
    if (state[0]) state_next = state_next ^ TAPS;
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN)              state <= SEED;
    else if (load)            state <= (load_data == '0) ? SEED : load_data;
    else                      state <= state_next;
  end

endmodule

// File: rtl/rand_request_scheduler.sv
// Round-robin sharing of one LFSR among NUM_REQ requesters, bounded rejection sampling into 0..range.
// Optional feature: define RAND_SCHED_RESEED_EN to add the reseed_valid/reseed_data load ports.
module rand_request_scheduler
  import rand_sched_pkg::*;
#(
  parameter int                   NUM_REQ   = 4,
  parameter int                   OUT_BITS  = 4,
  parameter int                   LFSR_BITS = 16,
  parameter logic [LFSR_BITS-1:0] SEED      = LFSR_BITS'(DEFAULT_SEED),
  parameter int                   MAX_RETRY = 4
) (
  input  logic                               clk,
  input  logic                               resetN,
  input  logic [NUM_REQ-1:0]                 req,
  input  logic [NUM_REQ-1:0][OUT_BITS-1:0]   range,
`ifdef RAND_SCHED_RESEED_EN
  input  logic                               reseed_valid,
  input  logic [LFSR_BITS-1:0]               reseed_data,
`endif
  output logic [NUM_REQ-1:0]                 grant,
  output logic [OUT_BITS-1:0]                rand_out,
  output logic                               rand_valid
);

  localparam int IDX_W   = $clog2(NUM_REQ);
  localparam int RETRY_W = (MAX_RETRY > 1) ? $clog2(MAX_RETRY) : 1;
  localparam logic [RETRY_W-1:0] LAST_TRY = RETRY_W'(MAX_RETRY - 1);

  state_t                state, state_next;
  logic [IDX_W-1:0]      winner, winner_next, rr_ptr, rr_next, pick, cand;
  logic [RETRY_W-1:0]    retry_cnt, retry_next;
  logic [NUM_REQ-1:0]    grant_next;
  logic                  valid_next;
  logic [OUT_BITS-1:0]   out_next;
  logic [OUT_BITS-1:0]   range_lat, result, result_next, mask, masked;
  logic [LFSR_BITS-1:0]  lfsr;
  logic                  lfsr_load;
  logic [LFSR_BITS-1:0]  lfsr_load_data;
  logic                  lfsr_unused;

`ifdef RAND_SCHED_RESEED_EN
  assign lfsr_load      = reseed_valid;
  assign lfsr_load_data = reseed_data;
`else
  assign lfsr_load      = 1'b0;
  assign lfsr_load_data = '0;
`endif

  lfsr_core #(
    .WIDTH (LFSR_BITS),
    .TAPS  (LFSR_BITS'(LFSR_TAPS_16)),
    .SEED  (SEED)
  ) u_lfsr (
    .clk       (clk),
    .resetN    (resetN),
    .load      (lfsr_load),
    .load_data (lfsr_load_data),
    .state     (lfsr)
  );

  // Only the low OUT_BITS feed draws; the rest of the register is the generator's internal state.
  assign lfsr_unused = ^lfsr;

  assign mask   = OUT_BITS'(range_mask(MASK_W'(range_lat)));
  assign masked = lfsr[OUT_BITS-1:0] & mask;

  // Lowest rotation offset wins, so iterate downward and let later hits override.
  always_comb begin
    pick = rr_ptr;
    cand = '0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      cand = IDX_W'((int'(rr_ptr) + i) % NUM_REQ);
      if (req[cand]) pick = cand;
    end
  end

  always_comb begin
    state_next  = state;
    winner_next = winner;
    retry_next  = retry_cnt;
    rr_next     = rr_ptr;
    grant_next  = '0;
    valid_next  = 1'b0;
    out_next    = rand_out;
    result_next = result;
    case (state)
      IDLE: begin
        if (|req) begin
          winner_next = pick;
          retry_next  = '0;
          state_next  = DRAW;
        end
      end
      DRAW: begin
        if (!req[winner]) begin
          state_next = IDLE;
        end else if (masked <= range_lat) begin
          result_next = masked;
          state_next  = DELIVER;
        end else if (retry_cnt == LAST_TRY) begin
          // masked <= mask <= 2*range, so this wraps back into 0..range.
          result_next = masked - (range_lat + 1'b1);
          state_next  = DELIVER;
        end else begin
          retry_next = retry_cnt + 1'b1;
        end
      end
      DELIVER: begin
        grant_next = NUM_REQ'(1) << winner;
        valid_next = 1'b1;
        out_next   = result;
        rr_next    = winner;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state      <= IDLE;
      winner     <= '0;
      rr_ptr     <= IDX_W'(NUM_REQ - 1);
      retry_cnt  <= '0;
      grant      <= '0;
      rand_valid <= 1'b0;
      rand_out   <= '0;
    end else begin
      state      <= state_next;
      winner     <= winner_next;
      rr_ptr     <= rr_next;
      retry_cnt  <= retry_next;
      grant      <= grant_next;
      rand_valid <= valid_next;
      rand_out   <= out_next;
    end
  end

  always_ff @(posedge clk) begin
    if (state == IDLE && |req) range_lat <= range[pick];
    result <= result_next;
  end

endmodule

// File: tb/tb_rand_request_scheduler.sv
// Directed scoreboard bench for rand_request_scheduler (default MAX_RETRY=4 plus a MAX_RETRY=1 instance).
module tb_rand_request_scheduler;

  localparam int NR = 4;
  localparam int OB = 4;
  localparam int MAXR = 4;

  logic clk = 1'b0;
  logic resetN = 1'b0;
  logic [NR-1:0]         req = '0, req1 = '0;
  logic [NR-1:0][OB-1:0] rng = '0, rng1 = '0;
  logic [NR-1:0]         grant, grant1;
  logic [OB-1:0]         rand_out, rand_out1;
  logic                  rand_valid, rand_valid1;
  logic [15:0]           mlfsr;

  int n_cmp = 0;
  int n_fail = 0;

  typedef struct {
    int         idx;
    logic [3:0] val;
    int         lat;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  rand_request_scheduler #(.NUM_REQ(NR), .OUT_BITS(OB), .LFSR_BITS(16), .SEED(16'hACE1), .MAX_RETRY(MAXR)) u_dut (
    .clk(clk), .resetN(resetN), .req(req), .range(rng),
`ifdef RAND_SCHED_RESEED_EN
    .reseed_valid(1'b0), .reseed_data(16'h0000),
`endif
    .grant(grant), .rand_out(rand_out), .rand_valid(rand_valid)
  );

  rand_request_scheduler #(.NUM_REQ(NR), .OUT_BITS(OB), .LFSR_BITS(16), .SEED(16'hACE1), .MAX_RETRY(1)) u_dut1 (
    .clk(clk), .resetN(resetN), .req(req1), .range(rng1),
`ifdef RAND_SCHED_RESEED_EN
    .reseed_valid(1'b0), .reseed_data(16'h0000),
`endif
    .grant(grant1), .rand_out(rand_out1), .rand_valid(rand_valid1)
  );

  function automatic logic [15:0] step(input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
  endfunction

  // Reference random source: same sequence the scheduler owns, tracked cycle by cycle.
  always @(posedge clk or negedge resetN) begin
    if (!resetN) mlfsr <= 16'hACE1;
    else         mlfsr <= step(mlfsr);
  end

  function automatic logic [3:0] mk(input logic [3:0] r);
    logic [4:0] m = 5'd0;
    while (m < {1'b0, r}) m = (m << 1) | 5'd1;
    return m[3:0];
  endfunction

  // v0 is the source value at the arbitration edge; draws use the following values.
  function automatic void predict(input logic [15:0] v0, input logic [3:0] r, input int maxr,
                                  output logic [3:0] val, output int lat);
    logic [15:0] v = v0;
    logic [3:0]  d;
    val = 4'd0;
    lat = 0;
    for (int j = 1; j <= maxr; j++) begin
      v = step(v);
      d = v[3:0] & mk(r);
      if (d <= r) begin
        val = d; lat = j + 2; return;
      end
      if (j == maxr) begin
        val = d - (r + 4'd1); lat = j + 2; return;
      end
    end
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0d required %0d", tag, obs, exp_v);
    end
  endtask

  // Called at a negedge with the DUT idle and req already driven; returns at the negedge showing the grant.
  task automatic serve(input int idx, input logic [3:0] r, input logic [3:0] r_late,
                       output logic [3:0] v, output int l);
    exp_t e;
    bit   seen = 1'b0;
    int   lat = 0;
    rng[idx] = r;
    e.idx = idx;
    predict(mlfsr, r, MAXR, e.val, e.lat);
    sb.push_back(e);
    while (!seen && lat < 20) begin
      @(negedge clk);
      lat++;
      if (lat == 1) rng[idx] = r_late;
      seen = rand_valid;
    end
    e = sb.pop_front();
    check("grant_seen", 32'(seen), 32'd1);
    check("grant_vec", 32'(grant), 32'(1 << e.idx));
    check("rand_out", 32'(rand_out), 32'(e.val));
    check("latency", lat, e.lat);
    v = rand_out;
    l = lat;
  endtask

  initial begin
    logic [3:0] v;
    int         l;
    int         best;
    int         quiet;
    bit         found;
    logic [9:0] digits;
    logic [15:0] nx;
    exp_t       e1;

    // Reset values
    repeat (2) @(negedge clk);
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_valid", 32'(rand_valid), 32'd0);
    check("rst_out", 32'(rand_out), 32'd0);
    check("rst_grant1", 32'(grant1), 32'd0);
    resetN = 1'b1;
    @(negedge clk);
    check("idle_valid", 32'(rand_valid), 32'd0);

    // All four held: strict round robin, twice
    req = 4'b1111;
    for (int k = 0; k < NR; k++) begin
      serve(k, 4'd15, 4'd15, v, l);
      req[k] = 1'b0;
    end
    req = 4'b1111;
    for (int k = 0; k < NR; k++) begin
      serve(k, 4'd15, 4'd15, v, l);
      req[k] = 1'b0;
    end

    // Range 0 delivers 0 at best-case latency; output then holds with no pulse
    req = 4'b0100;
    serve(2, 4'd0, 4'd0, v, l);
    req = 4'b0000;
    @(negedge clk);
    check("pulse_grant", 32'(grant), 32'd0);
    check("pulse_valid", 32'(rand_valid), 32'd0);
    check("hold_out0", 32'(rand_out), 32'(v));

    // Long run on range 9 (includes fallback reductions)
    req = 4'b0001;
    digits = '0;
    best = 0;
    for (int n = 0; n < 2000; n++) begin
      serve(0, 4'd9, 4'd9, v, l);
      check("in_range9", 32'(v <= 4'd9), 32'd1);
      if (v <= 4'd9) digits[v] = 1'b1;
      if (l == 3) best++;
    end
    check("all_digits", 32'(digits), 32'h3FF);
    check("best_case_seen", 32'(best > 0), 32'd1);
    // Range change after latching is ignored
    serve(0, 4'd3, 4'd15, v, l);
    req = 4'b0000;
    @(negedge clk);
    check("hold_out", 32'(rand_out), 32'(v));
    rng[0] = 4'd9;

    // Withdraw in DRAW: no grant, rr_ptr stays at previous winner (2)
    req = 4'b0100;
    serve(2, 4'd5, 4'd5, v, l);
    req = 4'b1000;
    rng[3] = 4'd7;
    @(negedge clk);
    req = 4'b0000;
    quiet = 0;
    repeat (5) begin
      @(negedge clk);
      if (rand_valid) quiet++;
    end
    check("withdraw_nogrant", quiet, 0);
    req = 4'b1001;
    serve(3, 4'd7, 4'd7, v, l);
    req[3] = 1'b0;
    serve(0, 4'd9, 4'd9, v, l);
    req = 4'b1000;
    serve(3, 4'd7, 4'd7, v, l);
    @(negedge clk);
    req = 4'b0000;
    quiet = 0;
    repeat (5) begin
      @(negedge clk);
      if (rand_valid) quiet++;
    end
    check("withdraw_nogrant2", quiet, 0);
    req = 4'b1001;
    serve(0, 4'd9, 4'd9, v, l);
    req = 4'b0000;
    @(negedge clk);

    // Reset asserted mid-DRAW
    req = 4'b0001;
    rng[0] = 4'd15;
    @(negedge clk);
    resetN = 1'b0;
    #1;
    check("midrst_grant", 32'(grant), 32'd0);
    check("midrst_valid", 32'(rand_valid), 32'd0);
    check("midrst_out", 32'(rand_out), 32'd0);
    quiet = 0;
    repeat (3) begin
      @(negedge clk);
      if (rand_valid) quiet++;
    end
    check("midrst_nogrant", quiet, 0);
    resetN = 1'b1;
    req = 4'b0011;
    serve(0, 4'd15, 4'd15, v, l);
    req[0] = 1'b0;
    serve(1, 4'd15, 4'd15, v, l);
    req = 4'b0000;

    // MAX_RETRY=1 instance: wait for a draw of 13 against range 8 -> fallback 13-9=4
    found = 1'b0;
    for (int c = 0; c < 2000 && !found; c++) begin
      @(negedge clk);
      nx = step(mlfsr);
      if (nx[3:0] == 4'd13) found = 1'b1;
    end
    check("force13_found", 32'(found), 32'd1);
    rng1[1] = 4'd8;
    req1 = 4'b0010;
    e1.idx = 1; e1.val = 4'd4; e1.lat = 3;
    sb.push_back(e1);
    l = 0;
    found = 1'b0;
    while (!found && l < 20) begin
      @(negedge clk);
      l++;
      found = rand_valid1;
    end
    req1 = 4'b0000;
    e1 = sb.pop_front();
    check("r1_seen", 32'(found), 32'd1);
    check("r1_grant", 32'(grant1), 32'(1 << e1.idx));
    check("r1_out", 32'(rand_out1), 32'(e1.val));
    check("r1_latency", l, e1.lat);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
